// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage with a one-entry skid buffer and redirect handling.
// Latency: imem_resp data reaches if_pc_o/if_ir_o on the next rising edge (one cycle),
//   or one cycle after stall_i drops if the instruction was parked in the skid buffer.
// Backpressure: stall_i freezes the output registers; a response that arrives under stall
//   is parked in the skid buffer and no new request is issued until it drains.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   stall_i                       decode cannot accept this cycle
//   redirect_i, redirect_pc_i     flush and refetch from redirect_pc_i
//   imem_read, imem_address       instruction memory request (held stable until imem_resp)
//   imem_resp, imem_rdata         one-cycle response pulse and instruction word
//   if_pc_o, if_ir_o, if_valid_o  instruction presented to decode (if_valid_o=0 is a bubble)
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_ir_o,
  output logic        if_valid_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_HOLD = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;           // next PC to fetch
  logic [31:0] drop_pc_q, drop_pc_d; // address of the in-flight request being discarded
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_ir_q, skid_ir_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_ir_q, out_ir_d;
  logic        out_vld_q, out_vld_d;

  logic [31:0] redirect_tgt;
  logic [31:0] pc_inc;

  // Targets are always word aligned; the low two bits are simply masked off.
  assign redirect_tgt = redirect_pc_i & 32'hFFFF_FFFC;
  assign pc_inc       = pc_q + 32'd4;

  // HOLD issues nothing; DROP keeps presenting the abandoned address so the
  // memory handshake stays stable until its response retires it.
  assign imem_read    = (state_q != ST_HOLD);
  assign imem_address = (state_q == ST_DROP) ? drop_pc_q : pc_q;

  assign if_pc_o    = out_pc_q;
  assign if_ir_o    = out_ir_q;
  assign if_valid_o = out_vld_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_pc_d = drop_pc_q;
    skid_pc_d = skid_pc_q;
    skid_ir_d = skid_ir_q;
    out_pc_d  = out_pc_q;
    out_ir_d  = out_ir_q;
    out_vld_d = out_vld_q;

    unique case (state_q)
      ST_REQ: begin
        if (redirect_i) begin
          pc_d      = redirect_tgt;
          out_vld_d = 1'b0;
          if (!imem_resp) begin
            // Request still in flight: remember its address and wait it out.
            drop_pc_d = pc_q;
            state_d   = ST_DROP;
          end
        end else if (imem_resp) begin
          pc_d = pc_inc;
          if (stall_i) begin
            skid_pc_d = pc_q;
            skid_ir_d = imem_rdata;
            state_d   = ST_HOLD;
          end else begin
            out_pc_d  = pc_q;
            out_ir_d  = imem_rdata;
            out_vld_d = 1'b1;
          end
        end else if (!stall_i) begin
          out_vld_d = 1'b0;
        end
      end

      ST_HOLD: begin
        if (redirect_i) begin
          pc_d      = redirect_tgt;
          out_vld_d = 1'b0;
          state_d   = ST_REQ;
        end else if (!stall_i) begin
          out_pc_d  = skid_pc_q;
          out_ir_d  = skid_ir_q;
          out_vld_d = 1'b1;
          state_d   = ST_REQ;
        end
      end

      ST_DROP: begin
        // Outputs are already a bubble here (entry is only via redirect).
        if (redirect_i) begin
          pc_d      = redirect_tgt;
          out_vld_d = 1'b0;
        end
        if (imem_resp) begin
          state_d = ST_REQ;
        end
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_REQ;
      pc_q      <= RESET_PC;
      drop_pc_q <= 32'h0;
      skid_pc_q <= 32'h0;
      skid_ir_q <= 32'h0;
      out_pc_q  <= 32'h0;
      out_ir_q  <= NOP;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      drop_pc_q <= drop_pc_d;
      skid_pc_q <= skid_pc_d;
      skid_ir_q <= skid_ir_d;
      out_pc_q  <= out_pc_d;
      out_ir_q  <= out_ir_d;
      out_vld_q <= out_vld_d;
    end
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h4000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stall_i  input  1  downstream (IF/ID) cannot accept; output registers SHALL hold.
REQ-005 redirect_i  input  1  taken branch/jump from EX; flush and refetch.
REQ-006 redirect_pc_i  input  32  target PC, valid when redirect_i=1.
REQ-007 imem_read  output  1  instruction memory read request.
REQ-008 imem_address  output  32  fetch address, word-aligned.
REQ-009 imem_resp  input  1  one-cycle pulse: imem_rdata valid, request complete.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 if_pc_o  output  32  PC of the instruction presented to decode.
REQ-012 if_ir_o  output  32  instruction word presented to decode.
REQ-013 if_valid_o  output  1  if_pc_o/if_ir_o hold a real instruction; 0 = bubble.

Function
REQ-014 State machine: REQ (request outstanding), HOLD (instruction parked in skid buffer), DROP (outstanding request to be discarded).
REQ-015 Memory handshake: imem_read=1 in REQ and DROP, 0 in HOLD; imem_address and imem_read SHALL stay stable from assertion until the imem_resp cycle.
REQ-016 imem_address = fetch PC register in REQ; the address of the in-flight request in DROP.
REQ-017 REQ, imem_resp=1, no redirect, stall_i=0: output regs <= {pc, imem_rdata}, if_valid_o<=1, pc<=pc+4, stay REQ; back-to-back fetch, one instruction per resp.
REQ-018 REQ, imem_resp=1, no redirect, stall_i=1: skid <= {pc, imem_rdata}, pc<=pc+4, output regs unchanged, go HOLD.
REQ-019 REQ, imem_resp=0, no redirect, stall_i=0: if_valid_o<=0 (bubble); stall_i=1: output regs unchanged.
REQ-020 HOLD, stall_i=1, no redirect: all state held. HOLD, stall_i=0: output regs <= skid, if_valid_o<=1, go REQ.
REQ-021 Redirect priority over stall_i: any cycle with redirect_i=1 sets if_valid_o<=0 and pc<=redirect_pc_i regardless of stall_i.
REQ-022 Redirect in REQ with imem_resp=1: imem_rdata discarded, go/stay REQ at new pc.
REQ-023 Redirect in REQ with imem_resp=0: latch in-flight address, go DROP; memory request not aborted.
REQ-024 DROP: imem_resp=1 -> data discarded, go REQ at pc; further redirect in DROP overwrites pc (last target wins), stay DROP unless imem_resp=1.
REQ-025 Redirect in HOLD: skid discarded, go REQ at new pc.
REQ-026 PC arithmetic: 32-bit unsigned, pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000; redirect_pc_i[1:0] ignored (forced 0).
REQ-027 if_pc_o/if_ir_o SHALL only change on cycles where stall_i=0 or redirect_i=1.
REQ-028 No instruction dropped or duplicated: decode sees every fetched, non-flushed instruction exactly once, in PC order.

Reset
REQ-029 rst=1 at edge: pc<=RESET_PC, state<=REQ, if_valid_o<=0, if_pc_o<=0, if_ir_o<=32'h0000_0013 (NOP), skid cleared; dominates redirect_i/stall_i.
REQ-030 Reset mid-request: first post-reset cycle drives imem_read=1, imem_address=RESET_PC; a stale imem_resp arriving in that cycle is accepted as RESET_PC data (memory is reset by the same rst).

Verification
REQ-031 Reset, resp every cycle, no stall -> imem_address 0x4000_0000,04,08...; if_valid_o=1 from cycle 2, if_pc_o follows one cycle behind.
REQ-032 Resp for 0x4000_0004 with stall_i=1 for 3 cycles -> HOLD, imem_read=0, outputs frozen; stall release -> if_pc_o=0x4000_0004 for exactly one accepted cycle, next fetch 0x4000_0008.
REQ-033 Redirect to 0x4000_0100 while request 0x4000_0010 pending, resp 2 cycles later -> imem_address stays 0x4000_0010 until resp, data discarded, next imem_address 0x4000_0100, no valid for 0x4000_0010.
REQ-034 Redirect same cycle as resp and stall_i=1 -> if_valid_o=0 next cycle, next imem_address=redirect target.
REQ-035 Two redirects (0x200 then 0x300) during DROP -> fetch resumes at 0x300 only.
REQ-036 pc=0xFFFF_FFFC resp -> next imem_address 0x0000_0000; rst asserted mid-HOLD -> next cycle imem_address=0x4000_0000, if_valid_o=0.
